// File: rtl/ifu_fetch_ctrl.sv
// Fetch-request stage: issues next-PC memory requests, filters stale
// responses after redirects and queues 8-byte fetch blocks for decode.
module ifu_fetch_ctrl #(
    parameter int MXLEN     = 64,
    parameter int FQ_DEPTH  = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [MXLEN-1:0] i_pcGen_nPc,
    input  logic             i_pcGen_nPcFetch_valid,
    input  logic             i_flush,
    output logic             o_ifu_stall,
    output logic             o_req_valid,
    output logic [MXLEN-1:0] o_req_addr,
    input  logic             i_req_ready,
    input  logic             i_rsp_valid,
    input  logic [63:0]      i_rsp_data,
    input  logic             i_rsp_err,
    output logic             o_fq_valid,
    output logic [MXLEN-1:0] o_fq_pc,
    output logic [63:0]      o_fq_instr,
    output logic [1:0]       o_fq_mask,
    output logic             o_fq_err,
    input  logic             i_fq_ready
);

    localparam int QW = $clog2(FQ_DEPTH);
    localparam int CW = QW + 1;
    localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int SW = CW + OW;

    typedef struct packed {
        logic [MXLEN-1:0] pc;
        logic [63:0]      data;
        logic [1:0]       mask;
        logic             err;
    } fq_ent_t;

    logic             pend_v;
    logic [MXLEN-1:0] pend_pc;
    logic [OW-1:0]    outst;
    logic [OW-1:0]    outst_nxt;
    logic [OW-1:0]    drop;

    logic [MXLEN-1:0] af_mem [MAX_OUTST];
    logic [AW-1:0]    af_wr;
    logic [AW-1:0]    af_rd;

    fq_ent_t          fq_mem [FQ_DEPTH];
    logic [QW-1:0]    fq_wr;
    logic [QW-1:0]    fq_rd;
    logic [CW-1:0]    fq_cnt;

    logic             credit_ok;
    logic             fire;
    logic             cap;
    logic             fq_push;
    logic             fq_pop;
    logic             fq_full;
    logic [MXLEN-1:0] rsp_pc;
    fq_ent_t          head;

    assign credit_ok = ((SW'(fq_cnt) + SW'(outst)) < SW'(FQ_DEPTH))
                     && (outst < OW'(MAX_OUTST));

    // No combinational path from i_req_ready into the request valid.
    assign o_req_valid = pend_v & credit_ok & ~i_flush;
    assign fire        = o_req_valid & i_req_ready;
    assign o_ifu_stall = pend_v & ~fire & ~i_flush;
    assign cap         = i_pcGen_nPcFetch_valid & ~o_ifu_stall;
    assign o_req_addr  = {pend_pc[MXLEN-1:3], 3'b000};

    assign outst_nxt = outst + OW'(fire) - OW'(i_rsp_valid);
    assign rsp_pc    = af_mem[af_rd];
    assign fq_push   = i_rsp_valid & (drop == '0) & ~i_flush;
    assign fq_full   = (fq_cnt == CW'(FQ_DEPTH));
    assign fq_pop    = o_fq_valid & i_fq_ready & ~i_flush;

    assign head       = fq_mem[fq_rd];
    assign o_fq_valid = (fq_cnt != '0);
    assign o_fq_pc    = o_fq_valid ? head.pc   : '0;
    assign o_fq_instr = o_fq_valid ? head.data : '0;
    assign o_fq_mask  = o_fq_valid ? head.mask : '0;
    assign o_fq_err   = o_fq_valid ? head.err  : 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_v  <= 1'b0;
            pend_pc <= '0;
        end else if (cap) begin
            pend_v  <= 1'b1;
            pend_pc <= i_pcGen_nPc;
        end else if (fire | i_flush) begin
            pend_v  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outst <= '0;
            drop  <= '0;
            af_wr <= '0;
            af_rd <= '0;
        end else begin
            outst <= outst_nxt;
            if (i_flush) begin
                drop <= outst_nxt;
            end else if (i_rsp_valid && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
            if (fire) begin
                af_wr <= (MAX_OUTST == 1) ? '0 : af_wr + 1'b1;
            end
            if (i_rsp_valid) begin
                af_rd <= (MAX_OUTST == 1) ? '0 : af_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fire) begin
            af_mem[af_wr] <= pend_pc;
        end
        if (fq_push) begin
            fq_mem[fq_wr] <= '{
                pc:   rsp_pc,
                data: i_rsp_data,
                mask: rsp_pc[2] ? 2'b10 : 2'b11,
                err:  i_rsp_err
            };
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fq_wr  <= '0;
            fq_rd  <= '0;
            fq_cnt <= '0;
        end else if (i_flush) begin
            fq_rd  <= fq_wr;
            fq_cnt <= '0;
        end else begin
            if (fq_push) begin
                fq_wr <= fq_wr + 1'b1;
            end
            if (fq_pop) begin
                fq_rd <= fq_rd + 1'b1;
            end
            fq_cnt <= fq_cnt + CW'(fq_push) - CW'(fq_pop);
        end
    end

    // Credit reserves a slot for every in-flight response.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(fq_push && fq_full && !fq_pop));
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_ifu_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_pcGen_nPc;
    logic        i_pcGen_nPcFetch_valid;
    logic        i_flush;
    logic        o_ifu_stall;
    logic        o_req_valid;
    logic [63:0] o_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [63:0] i_rsp_data;
    logic        i_rsp_err;
    logic        o_fq_valid;
    logic [63:0] o_fq_pc;
    logic [63:0] o_fq_instr;
    logic [1:0]  o_fq_mask;
    logic        o_fq_err;
    logic        i_fq_ready;

    always #5 i_clk = ~i_clk;

    ifu_fetch_ctrl #(.MXLEN(64), .FQ_DEPTH(4), .MAX_OUTST(2)) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_pcGen_nPc            (i_pcGen_nPc),
        .i_pcGen_nPcFetch_valid (i_pcGen_nPcFetch_valid),
        .i_flush                (i_flush),
        .o_ifu_stall            (o_ifu_stall),
        .o_req_valid            (o_req_valid),
        .o_req_addr             (o_req_addr),
        .i_req_ready            (i_req_ready),
        .i_rsp_valid            (i_rsp_valid),
        .i_rsp_data             (i_rsp_data),
        .i_rsp_err              (i_rsp_err),
        .o_fq_valid             (o_fq_valid),
        .o_fq_pc                (o_fq_pc),
        .o_fq_instr             (o_fq_instr),
        .o_fq_mask              (o_fq_mask),
        .o_fq_err               (o_fq_err),
        .i_fq_ready             (i_fq_ready)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
        logic [1:0]  mask;
        logic        err;
    } ent_t;

    typedef struct {
        logic [63:0] pc;
        bit          stale;
    } fl_t;

    ent_t        fq[$];
    fl_t         infl[$];
    logic [63:0] memq[$];
    bit          m_pv;
    logic [63:0] m_pc;
    int          total = 0;
    int          bad = 0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic setin(logic v, logic [63:0] npc, logic fl, logic rdy,
                         logic rv, logic [63:0] d, logic e, logic fr);
        i_pcGen_nPcFetch_valid = v;
        i_pcGen_nPc            = npc;
        i_flush                = fl;
        i_req_ready            = rdy;
        i_rsp_valid            = rv;
        i_rsp_data             = d;
        i_rsp_err              = e;
        i_fq_ready             = fr;
    endtask

    task automatic idle(logic fr);
        setin(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, fr);
    endtask

    // Compare the DUT against the model, advance the model one clock.
    task automatic cyc();
        int   occ;
        bit   cr, rv, fire, st, cap;
        ent_t h;
        fl_t  f;
        #1;
        occ  = fq.size() + infl.size();
        cr   = (occ < 4) && (infl.size() < 2);
        rv   = m_pv && cr && !i_flush;
        fire = rv && i_req_ready;
        st   = m_pv && !fire && !i_flush;
        cap  = i_pcGen_nPcFetch_valid && !st;
        h    = '{pc: 64'h0, data: 64'h0, mask: 2'b00, err: 1'b0};
        if (fq.size() > 0) h = fq[0];
        chk("req_valid", {63'h0, o_req_valid}, {63'h0, rv});
        chk("req_addr", o_req_addr, m_pc & ~64'h7);
        chk("stall", {63'h0, o_ifu_stall}, {63'h0, st});
        chk("fq_valid", {63'h0, o_fq_valid}, {63'h0, fq.size() > 0});
        chk("fq_pc", o_fq_pc, h.pc);
        chk("fq_instr", o_fq_instr, h.data);
        chk("fq_mask", {62'h0, o_fq_mask}, {62'h0, h.mask});
        chk("fq_err", {63'h0, o_fq_err}, {63'h0, h.err});
        if (i_flush) fq.delete();
        else if (fq.size() > 0 && i_fq_ready) void'(fq.pop_front());
        if (i_rsp_valid) begin
            if (infl.size() == 0) begin
                chk("rsp_without_request", 64'h0, 64'h1);
            end else begin
                f = infl.pop_front();
                if (!f.stale && !i_flush)
                    fq.push_back('{pc: f.pc, data: i_rsp_data,
                                   mask: f.pc[2] ? 2'b10 : 2'b11,
                                   err: i_rsp_err});
            end
        end
        if (fire) infl.push_back('{pc: m_pc, stale: 1'b0});
        if (i_flush) foreach (infl[i]) infl[i].stale = 1'b1;
        if (cap) begin
            m_pv = 1'b1;
            m_pc = i_pcGen_nPc;
        end else if (fire || i_flush) begin
            m_pv = 1'b0;
        end
        if (o_req_valid && i_req_ready) memq.push_back(o_req_addr);
        if (i_rsp_valid && memq.size() > 0) void'(memq.pop_front());
        @(negedge i_clk);
    endtask

    task automatic rand_cyc(int flush_mod, int fr_mode);
        logic        v, fl, rdy, rv, e, fr;
        logic [63:0] npc;
        v   = ($urandom % 3) != 0;
        npc = 64'h8000_0000 | {52'h0, 10'($urandom), 2'b00};
        fl  = (flush_mod > 0) && (($urandom % flush_mod) == 0);
        rdy = ($urandom % 4) != 0;
        rv  = (memq.size() > 0) && (($urandom % 3) != 0);
        e   = ($urandom % 8) == 0;
        fr  = (fr_mode == 2) ? 1'b1 : (fr_mode == 1) ? 1'($urandom) : 1'b0;
        setin(v, npc, fl, rdy, rv, {$urandom, $urandom}, e, fr);
        cyc();
    endtask

    initial begin
        i_rst = 1'b1;
        idle(1'b0);
        m_pv = 1'b0;
        m_pc = 64'h0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_req_valid", {63'h0, o_req_valid}, 64'h0);
        chk("rst_stall", {63'h0, o_ifu_stall}, 64'h0);
        chk("rst_fq_valid", {63'h0, o_fq_valid}, 64'h0);
        chk("rst_req_addr", o_req_addr, 64'h0);
        chk("rst_fq_pc", o_fq_pc, 64'h0);
        chk("rst_fq_instr", o_fq_instr, 64'h0);

        // Aligned fetch
        setin(1, 64'h8000_0008, 0, 1, 0, 64'h0, 0, 0); cyc();
        idle(0); #1;
        chk("d1_req_valid", {63'h0, o_req_valid}, 64'h1);
        chk("d1_addr", o_req_addr, 64'h8000_0008);
        cyc();
        setin(0, 64'h0, 0, 1, 1, 64'h0000_0013_0000_0073, 0, 0); cyc();
        idle(1); #1;
        chk("d1_fq_pc", o_fq_pc, 64'h8000_0008);
        chk("d1_fq_mask", {62'h0, o_fq_mask}, 64'h3);
        chk("d1_fq_instr", o_fq_instr, 64'h0000_0013_0000_0073);
        cyc();

        // Fetch from the upper word
        setin(1, 64'h8000_0004, 0, 1, 0, 64'h0, 0, 0); cyc();
        idle(0); #1;
        chk("d2_addr", o_req_addr, 64'h8000_0000);
        cyc();
        setin(0, 64'h0, 0, 1, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0); cyc();
        idle(1); #1;
        chk("d2_fq_pc", o_fq_pc, 64'h8000_0004);
        chk("d2_fq_mask", {62'h0, o_fq_mask}, 64'h2);
        cyc();

        // Memory not ready
        setin(1, 64'h8000_0010, 0, 0, 0, 64'h0, 0, 1); cyc();
        for (int i = 0; i < 3; i++) begin
            setin(0, 64'h0, 0, 0, 0, 64'h0, 0, 1); #1;
            chk("d3_stall", {63'h0, o_ifu_stall}, 64'h1);
            chk("d3_addr", o_req_addr, 64'h8000_0010);
            cyc();
        end
        idle(1); #1;
        chk("d3_stall_release", {63'h0, o_ifu_stall}, 64'h0);
        cyc();
        setin(0, 64'h0, 0, 1, 1, 64'h1234, 1, 1); cyc();
        idle(1); cyc();

        // Flush with two requests in flight
        setin(1, 64'h8000_0100, 0, 1, 0, 64'h0, 0, 1); cyc();
        setin(1, 64'h8000_0108, 0, 1, 0, 64'h0, 0, 1); cyc();
        idle(1); cyc();
        setin(1, 64'h8000_1000, 1, 1, 0, 64'h0, 0, 1); #1;
        chk("d5_flush_stall", {63'h0, o_ifu_stall}, 64'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            setin(0, 64'h0, 0, 1, 1, 64'h5555_0000 + 64'(i), 0, 0); #1;
            chk("d5_fq_empty", {63'h0, o_fq_valid}, 64'h0);
            cyc();
        end
        idle(1); #1;
        chk("d5_new_pc", o_fq_pc, 64'h8000_1000);
        cyc();

        // Flush coincident with the last response
        setin(1, 64'h8000_2000, 0, 1, 0, 64'h0, 0, 1); cyc();
        idle(1); cyc();
        setin(0, 64'h0, 1, 1, 1, 64'h7777, 0, 1); #1;
        chk("d6_flush_stall", {63'h0, o_ifu_stall}, 64'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle(1); #1;
            chk("d6_fq_empty", {63'h0, o_fq_valid}, 64'h0);
            cyc();
        end

        for (int i = 0; i < 1500; i++) rand_cyc(20, 1);
        for (int i = 0; i < 200; i++) rand_cyc(0, 0);
        #1;
        chk("credit_full_fq", {63'h0, o_fq_valid}, 64'h1);
        chk("credit_full_noreq", {63'h0, o_req_valid}, 64'h0);
        for (int i = 0; i < 1500; i++) rand_cyc(25, 1);
        for (int i = 0; i < 300; i++) rand_cyc(40, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
